// File: rtl/arm_pkg.sv
// Shared encodings for the ARM-subset pipeline: ALU commands, shift types, forwarding selects.
package arm_pkg;

  localparam int unsigned CMD_W   = 4;
  localparam int unsigned SHIFT_W = 2;
  localparam int unsigned FWD_W   = 2;

  localparam logic [CMD_W-1:0] CMD_MOV = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_MVN = 4'b1001;
  localparam logic [CMD_W-1:0] CMD_ADD = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_ADC = 4'b0011;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_SBC = 4'b0101;
  localparam logic [CMD_W-1:0] CMD_AND = 4'b0110;
  localparam logic [CMD_W-1:0] CMD_ORR = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_EOR = 4'b1000;

  localparam logic [SHIFT_W-1:0] SHIFT_LSL = 2'b00;
  localparam logic [SHIFT_W-1:0] SHIFT_LSR = 2'b01;
  localparam logic [SHIFT_W-1:0] SHIFT_ASR = 2'b10;
  localparam logic [SHIFT_W-1:0] SHIFT_ROR = 2'b11;

  localparam logic [FWD_W-1:0] FWD_REG     = 2'b00;
  localparam logic [FWD_W-1:0] FWD_MEM     = 2'b01;
  localparam logic [FWD_W-1:0] FWD_WB      = 2'b10;
  localparam logic [FWD_W-1:0] FWD_REG_ALT = 2'b11;

  // Operand source select shared by the Rn and Rm forwarding muxes.
  function automatic logic [31:0] fwd_select(input logic [FWD_W-1:0] sel,
                                             input logic [31:0] reg_val,
                                             input logic [31:0] mem_val,
                                             input logic [31:0] wb_val);
    logic [31:0] v;
    v = reg_val;
    case (sel)
      FWD_MEM:     v = mem_val;
      FWD_WB:      v = wb_val;
      FWD_REG_ALT: v = reg_val;
      default:     v = reg_val;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/val2_generator.sv
// Second ALU operand: memory offset, rotated immediate, or shifted Rm.
module val2_generator
  import arm_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic [11:0]   shift_op,
  input  logic [DW-1:0] rm,
  input  logic          imm,
  input  logic          mem_en,
  output logic [DW-1:0] val2
);

  logic [DW-1:0]   imm32;
  logic [4:0]      rot_amt;
  logic [4:0]      sh_amt;
  logic [2*DW-1:0] imm_dbl;
  logic [2*DW-1:0] rm_dbl;

  // Rotations use a doubled word so a zero amount needs no special case.
  always_comb begin
    imm32   = DW'(shift_op[7:0]);
    rot_amt = {shift_op[11:8], 1'b0};
    sh_amt  = shift_op[11:7];
    imm_dbl = {imm32, imm32} >> rot_amt;
    rm_dbl  = {rm, rm} >> sh_amt;
    val2    = rm;
    if (mem_en) begin
      val2 = DW'(shift_op);
    end else if (imm) begin
      val2 = imm_dbl[DW-1:0];
    end else begin
      case (shift_op[6:5])
        SHIFT_LSL: val2 = rm << sh_amt;
        SHIFT_LSR: val2 = rm >> sh_amt;
        SHIFT_ASR: val2 = DW'($signed(rm) >>> sh_amt);
        SHIFT_ROR: val2 = rm_dbl[DW-1:0];
        default:   val2 = rm;
      endcase
    end
  end

endmodule

// File: rtl/exe_stage_pipe.sv
// Execute stage: forwarding, Val2, ALU, NZCV register and EXE/MEM register.
module exe_stage_pipe
  import arm_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_en_in,
  input  logic             mem_r_en_in,
  input  logic             mem_w_en_in,
  input  logic             b_in,
  input  logic             s_in,
  input  logic             imm_in,
  input  logic [CMD_W-1:0] exe_cmd_in,
  input  logic [3:0]       dest_in,
  input  logic [11:0]      shift_op_in,
  input  logic [23:0]      simm24_in,
  input  logic [DW-1:0]    pc_in,
  input  logic [DW-1:0]    val_rn_in,
  input  logic [DW-1:0]    val_rm_in,
  input  logic [FWD_W-1:0] fwd_sel1,
  input  logic [FWD_W-1:0] fwd_sel2,
  input  logic [DW-1:0]    mem_fwd,
  input  logic [DW-1:0]    wb_fwd,
  output logic [3:0]       status_r,
  output logic             branch_taken,
  output logic [DW-1:0]    branch_addr,
  output logic             wb_en,
  output logic             mem_r_en,
  output logic             mem_w_en,
  output logic [DW-1:0]    alu_res,
  output logic [DW-1:0]    st_val,
  output logic [3:0]       dest
);

  localparam int unsigned SW = DW + 1;

  logic [DW-1:0] rn_v;
  logic [DW-1:0] rm_v;
  logic [DW-1:0] val2;
  logic [DW-1:0] bop;
  logic [DW-1:0] res;
  logic [SW-1:0] sum;
  logic          cin;
  logic          is_arith;
  logic          is_valid;
  logic [3:0]    flags_nxt;

  // Forwarded operands; Rm feeds both Val2 and the store data.
  always_comb begin
    rn_v = fwd_select(fwd_sel1, val_rn_in, mem_fwd, wb_fwd);
    rm_v = fwd_select(fwd_sel2, val_rm_in, mem_fwd, wb_fwd);
  end

  val2_generator #(.DW(DW)) u_val2 (
    .shift_op (shift_op_in),
    .rm       (rm_v),
    .imm      (imm_in),
    .mem_en   (mem_r_en_in | mem_w_en_in),
    .val2     (val2)
  );

  // Branch redirect back to IF.
  always_comb begin
    branch_taken = b_in;
    branch_addr  = pc_in + {{(DW-26){simm24_in[23]}}, simm24_in, 2'b00};
  end

  // ALU with a 33-bit adder; subtraction is Rn + ~Val2 + 1 so carry means no borrow.
  always_comb begin
    cin       = status_r[1];
    sum       = '0;
    bop       = val2;
    res       = '0;
    is_arith  = 1'b0;
    is_valid  = 1'b1;
    flags_nxt = status_r;
    case (exe_cmd_in)
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_ADD: begin
        sum = {1'b0, rn_v} + {1'b0, val2};
        is_arith = 1'b1;
      end
      CMD_ADC: begin
        sum = {1'b0, rn_v} + {1'b0, val2} + SW'(cin);
        is_arith = 1'b1;
      end
      CMD_SUB: begin
        bop = ~val2;
        sum = {1'b0, rn_v} + {1'b0, ~val2} + SW'(1);
        is_arith = 1'b1;
      end
      CMD_SBC: begin
        bop = ~val2;
        sum = {1'b0, rn_v} + {1'b0, ~val2} + SW'(cin);
        is_arith = 1'b1;
      end
      CMD_AND: res = rn_v & val2;
      CMD_ORR: res = rn_v | val2;
      CMD_EOR: res = rn_v ^ val2;
      default: is_valid = 1'b0;
    endcase
    if (is_arith) begin
      res = sum[DW-1:0];
    end
    if (is_valid) begin
      flags_nxt[3] = res[DW-1];
      flags_nxt[2] = (res == '0);
    end
    if (is_arith) begin
      flags_nxt[1] = sum[DW];
      flags_nxt[0] = (rn_v[DW-1] == bop[DW-1]) && (res[DW-1] != rn_v[DW-1]);
    end
  end

  // NZCV register: updates only for non-branch S instructions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_r <= '0;
    end else if (s_in && !b_in) begin
      status_r <= flags_nxt;
    end
  end

  // EXE/MEM register, loaded every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en    <= 1'b0;
      mem_r_en <= 1'b0;
      mem_w_en <= 1'b0;
      alu_res  <= '0;
      st_val   <= '0;
      dest     <= '0;
    end else begin
      wb_en    <= wb_en_in;
      mem_r_en <= mem_r_en_in;
      mem_w_en <= mem_w_en_in;
      alu_res  <= res;
      st_val   <= rm_v;
      dest     <= dest_in;
    end
  end

endmodule

// File: tb/tb_exe_stage_pipe.sv
// Directed bench for exe_stage_pipe with hand-computed expectations.
module tb_exe_stage_pipe;
  import arm_pkg::*;

  logic        clk;
  logic        rst;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
  logic [3:0]  exe_cmd_in, dest_in;
  logic [11:0] shift_op_in;
  logic [23:0] simm24_in;
  logic [31:0] pc_in, val_rn_in, val_rm_in, mem_fwd, wb_fwd;
  logic [1:0]  fwd_sel1, fwd_sel2;
  logic [3:0]  status_r;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        wb_en, mem_r_en, mem_w_en;
  logic [31:0] alu_res, st_val;
  logic [3:0]  dest;

  int n_checks = 0;
  int n_errors = 0;

  exe_stage_pipe #(.DW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_en_in     (wb_en_in),
    .mem_r_en_in  (mem_r_en_in),
    .mem_w_en_in  (mem_w_en_in),
    .b_in         (b_in),
    .s_in         (s_in),
    .imm_in       (imm_in),
    .exe_cmd_in   (exe_cmd_in),
    .dest_in      (dest_in),
    .shift_op_in  (shift_op_in),
    .simm24_in    (simm24_in),
    .pc_in        (pc_in),
    .val_rn_in    (val_rn_in),
    .val_rm_in    (val_rm_in),
    .fwd_sel1     (fwd_sel1),
    .fwd_sel2     (fwd_sel2),
    .mem_fwd      (mem_fwd),
    .wb_fwd       (wb_fwd),
    .status_r     (status_r),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .wb_en        (wb_en),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .alu_res      (alu_res),
    .st_val       (st_val),
    .dest         (dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; b_in = 0; s_in = 0; imm_in = 0;
    exe_cmd_in = 4'b0000; dest_in = 4'h0; shift_op_in = 12'h000; simm24_in = 24'h0;
    pc_in = 32'h0; val_rn_in = 32'h0; val_rm_in = 32'h0; mem_fwd = 32'h0; wb_fwd = 32'h0;
    fwd_sel1 = FWD_REG; fwd_sel2 = FWD_REG;
  endtask

  task automatic set_alu(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                         input logic [11:0] sop, input logic imm, input logic s);
    idle();
    exe_cmd_in = cmd; val_rn_in = rn; val_rm_in = rm; shift_op_in = sop; imm_in = imm; s_in = s;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #2 rst = 1'b0;
    #2;
    check("rst_alu_res", alu_res, 32'h0);
    check("rst_status", 32'(status_r), 32'h0);
    check("rst_ctrl", 32'({wb_en, mem_r_en, mem_w_en, dest}), 32'h0);
    check("rst_st_val", st_val, 32'h0);
    step();
    rst = 1'b1;

    // 1: ADD 5 + #7, no S
    set_alu(CMD_ADD, 32'd5, 32'd0, 12'h007, 1'b1, 1'b0);
    wb_en_in = 1'b1; dest_in = 4'd3;
    step();
    check("add_res", alu_res, 32'd12);
    check("add_status", 32'(status_r), 32'h0);
    check("add_ctrl", 32'({wb_en, dest}), 32'h13);

    // 2: SUBS 3 - 5, then ADC 1 + #1 reading C=0
    set_alu(CMD_SUB, 32'd3, 32'd5, 12'h000, 1'b0, 1'b1);
    step();
    check("subs_res", alu_res, 32'hFFFF_FFFE);
    check("subs_status", 32'(status_r), 32'h8);
    set_alu(CMD_ADC, 32'd1, 32'd0, 12'h001, 1'b1, 1'b0);
    step();
    check("adc_c0_res", alu_res, 32'd2);
    check("adc_c0_status", 32'(status_r), 32'h8);

    // 3: Val2 forms
    set_alu(CMD_MOV, 32'd0, 32'd0, 12'h4FF, 1'b1, 1'b0);
    step();
    check("imm_rot", alu_res, 32'hFF00_0000);
    set_alu(CMD_MOV, 32'd0, 32'h8000_0000, 12'h0C0, 1'b0, 1'b0);
    step();
    check("asr1", alu_res, 32'hC000_0000);
    set_alu(CMD_MOV, 32'd0, 32'h8000_0000, 12'h220, 1'b0, 1'b0);
    step();
    check("lsr4", alu_res, 32'h0800_0000);
    set_alu(CMD_MOV, 32'd0, 32'h1234_5678, 12'h460, 1'b0, 1'b0);
    step();
    check("ror8", alu_res, 32'h7812_3456);
    set_alu(CMD_MOV, 32'd0, 32'h1234_5678, 12'h060, 1'b0, 1'b0);
    step();
    check("ror0_pass", alu_res, 32'h1234_5678);

    // Flag behaviour
    set_alu(CMD_ADD, 32'hFFFF_FFFF, 32'd0, 12'h001, 1'b1, 1'b1);
    step();
    check("adds_carry_res", alu_res, 32'h0);
    check("adds_carry_status", 32'(status_r), 32'h6);
    set_alu(CMD_ADC, 32'd0, 32'd0, 12'h000, 1'b1, 1'b0);
    step();
    check("adc_c1_res", alu_res, 32'd1);
    set_alu(CMD_ADD, 32'h7FFF_FFFF, 32'd0, 12'h001, 1'b1, 1'b1);
    step();
    check("adds_ovf_res", alu_res, 32'h8000_0000);
    check("adds_ovf_status", 32'(status_r), 32'h9);
    set_alu(CMD_AND, 32'h0000_00F0, 32'd0, 12'h00F, 1'b1, 1'b1);
    step();
    check("ands_res", alu_res, 32'h0);
    check("ands_keep_cv", 32'(status_r), 32'h5);
    set_alu(4'b0000, 32'd5, 32'd0, 12'h007, 1'b1, 1'b1);
    step();
    check("bad_cmd_res", alu_res, 32'h0);
    check("bad_cmd_status", 32'(status_r), 32'h5);
    set_alu(CMD_MVN, 32'd0, 32'd0, 12'h000, 1'b1, 1'b1);
    step();
    check("mvns_res", alu_res, 32'hFFFF_FFFF);
    check("mvns_status", 32'(status_r), 32'h9);
    set_alu(CMD_ORR, 32'h0000_00F0, 32'd0, 12'h00F, 1'b1, 1'b0);
    step();
    check("orr_res", alu_res, 32'h0000_00FF);
    set_alu(CMD_EOR, 32'h0000_00FF, 32'd0, 12'h00F, 1'b1, 1'b0);
    step();
    check("eor_res", alu_res, 32'h0000_00F0);
    set_alu(CMD_SBC, 32'd5, 32'd0, 12'h002, 1'b1, 1'b1);
    step();
    check("sbcs_res", alu_res, 32'd2);
    check("sbcs_status", 32'(status_r), 32'h2);

    // 4: forwarding
    set_alu(CMD_ADD, 32'd1, 32'd0, 12'h001, 1'b1, 1'b0);
    mem_fwd = 32'd100; fwd_sel1 = FWD_MEM;
    step();
    check("fwd_mem_rn", alu_res, 32'd101);
    set_alu(CMD_ADD, 32'd1, 32'd0, 12'h001, 1'b1, 1'b0);
    wb_fwd = 32'd1000; mem_fwd = 32'd100; fwd_sel1 = FWD_WB;
    step();
    check("fwd_wb_rn", alu_res, 32'd1001);
    set_alu(CMD_ADD, 32'd1, 32'd0, 12'h001, 1'b1, 1'b0);
    wb_fwd = 32'd1000; mem_fwd = 32'd100; fwd_sel1 = FWD_REG_ALT;
    step();
    check("fwd_alt_rn", alu_res, 32'd2);
    set_alu(CMD_ADD, 32'h0000_1000, 32'd5, 12'h004, 1'b0, 1'b0);
    mem_w_en_in = 1'b1; wb_fwd = 32'hDEAD_BEEF; fwd_sel2 = FWD_WB;
    step();
    check("store_addr", alu_res, 32'h0000_1004);
    check("store_data", st_val, 32'hDEAD_BEEF);
    check("store_ctrl", 32'({wb_en, mem_r_en, mem_w_en}), 32'h1);
    set_alu(CMD_ADD, 32'h0000_1000, 32'd0, 12'h4FF, 1'b1, 1'b0);
    mem_r_en_in = 1'b1; wb_en_in = 1'b1;
    step();
    check("load_zext_off", alu_res, 32'h0000_14FF);
    check("load_ctrl", 32'({wb_en, mem_r_en, mem_w_en}), 32'h6);

    // 5: branch with S set must not touch flags
    set_alu(CMD_SUB, 32'd3, 32'd5, 12'h000, 1'b0, 1'b1);
    b_in = 1'b1; pc_in = 32'h0000_0100; simm24_in = 24'hFFFFFE;
    #1;
    check("br_addr", branch_addr, 32'h0000_00F8);
    check("br_taken", 32'(branch_taken), 32'h1);
    step();
    check("br_status_hold", 32'(status_r), 32'h2);
    check("br_res", alu_res, 32'hFFFF_FFFE);

    // 6: asynchronous reset mid-cycle
    set_alu(CMD_ADD, 32'hFFFF_FFFF, 32'h55, 12'h007, 1'b1, 1'b1);
    mem_r_en_in = 1'b1; wb_en_in = 1'b1; dest_in = 4'd9;
    step();
    check("pre_rst_res", alu_res, 32'd6);
    check("pre_rst_status", 32'(status_r), 32'h2);
    #2 rst = 1'b0;
    #1;
    check("midrst_res", alu_res, 32'h0);
    check("midrst_status", 32'(status_r), 32'h0);
    check("midrst_ctrl", 32'({wb_en, mem_r_en, mem_w_en, dest}), 32'h0);
    check("midrst_st_val", st_val, 32'h0);
    #1 rst = 1'b1;
    set_alu(CMD_ADD, 32'd5, 32'd0, 12'h007, 1'b1, 1'b0);
    wb_en_in = 1'b1; dest_in = 4'd4;
    step();
    check("post_rst_res", alu_res, 32'd12);
    check("post_rst_ctrl", 32'({wb_en, dest}), 32'h14);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
